// File: rtl/bch_llr_loader_if.sv
// LLR beat stream between the channel front-end and the BCH loader.
// Carries a valid/ready handshake with one packed beat of LANES LLRs per transfer.
interface bch_llr_loader_if #(
    parameter int unsigned LANES = 8,
    parameter int unsigned LLR_W = 8
);
    logic                     in_valid;
    logic [LANES*LLR_W-1:0]   idata;
    logic                     ready;

    modport master (output in_valid, output idata, input  ready);
    modport slave  (input  in_valid, input  idata, output ready);
endinterface

// File: rtl/bch_llr_loader.sv
// BCH decoder input front-end: unpacks LLR beats into hard bits per code position
// and, in soft mode, tracks the two least-reliable positions.
module bch_llr_loader #(
    parameter int unsigned LANES = 8,
    parameter int unsigned LLR_W = 8,
    parameter int unsigned MAX_N = 1023,
    parameter int unsigned IDX_W = 10
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               set,
    input  logic [1:0]         code,
    input  logic               mode,
    bch_llr_loader_if.slave    llr,
    output logic               load_done,
    output logic [MAX_N-1:0]   hd_bits,
    output logic               lr_valid,
    output logic [IDX_W-1:0]   lr_idx0,
    output logic [IDX_W-1:0]   lr_idx1
);

    localparam int unsigned MAG_W     = LLR_W - 1;
    localparam int unsigned MAX_BEATS = (MAX_N + 1) / LANES;
    localparam int unsigned CNT_W     = $clog2(MAX_BEATS + 1);
    localparam logic [MAG_W-1:0] MAG_MAX = '1;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t              state;
    logic [1:0]          code_reg;
    logic                mode_reg;
    logic [CNT_W-1:0]    cnt;
    logic [MAG_W-1:0]    min0, min1;
    logic                occ0, occ1;

    logic [IDX_W-1:0]              n_len;
    logic [CNT_W-1:0]              last_cnt;
    logic [IDX_W-1:0]              base;
    logic [LANES-1:0][MAG_W-1:0]   mag;
    logic [LANES-1:0][IDX_W-1:0]   pos;
    logic [LANES-1:0]              sgn;
    logic [LANES-1:0]              lane_ok;
    logic                          accept;
    logic [MAG_W-1:0]              ins0_m, ins1_m;
    logic [IDX_W-1:0]              ins0_i, ins1_i;
    logic                          ins0_v, ins1_v;

    function automatic logic [IDX_W-1:0] code_len(input logic [1:0] c);
        case (c)
            2'd1:    return IDX_W'(63);
            2'd2:    return IDX_W'(255);
            2'd3:    return IDX_W'(1023);
            default: return '0;
        endcase
    endfunction

    // Lane unpacking: position, sign and saturated magnitude of each LLR
    always_comb begin
        logic [LLR_W-1:0] lane_v;
        logic [LLR_W-1:0] neg_v;
        lane_v   = '0;
        neg_v    = '0;
        n_len    = code_len(code_reg);
        last_cnt = CNT_W'((32'(n_len) + 32'd1) / LANES - 32'd1);
        base     = n_len - IDX_W'(32'(cnt) * LANES);
        accept   = llr.in_valid && llr.ready && (state == LOAD);
        mag      = '0;
        pos      = '0;
        sgn      = '0;
        lane_ok  = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            lane_v     = llr.idata[(int'(LANES) - 1 - l) * int'(LLR_W) +: LLR_W];
            neg_v      = LLR_W'(0) - lane_v;
            sgn[l]     = lane_v[LLR_W-1];
            pos[l]     = base - IDX_W'(l);
            lane_ok[l] = (l != 0) || (cnt != '0);
            if (!lane_v[LLR_W-1])
                mag[l] = lane_v[MAG_W-1:0];
            else if (lane_v[MAG_W-1:0] == '0)
                mag[l] = MAG_MAX;
            else
                mag[l] = neg_v[MAG_W-1:0];
        end
    end

    // Lanes are inserted in arrival order with strict '<', so earlier symbols win ties
    always_comb begin
        ins0_m = min0;
        ins0_i = lr_idx0;
        ins0_v = occ0;
        ins1_m = min1;
        ins1_i = lr_idx1;
        ins1_v = occ1;
        for (int l = 0; l < int'(LANES); l++) begin
            if (lane_ok[l]) begin
                if (!ins0_v || (mag[l] < ins0_m)) begin
                    ins1_m = ins0_m;
                    ins1_i = ins0_i;
                    ins1_v = ins0_v;
                    ins0_m = mag[l];
                    ins0_i = pos[l];
                    ins0_v = 1'b1;
                end else if (!ins1_v || (mag[l] < ins1_m)) begin
                    ins1_m = mag[l];
                    ins1_i = pos[l];
                    ins1_v = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            code_reg  <= '0;
            mode_reg  <= 1'b0;
            cnt       <= '0;
            min0      <= MAG_MAX;
            min1      <= MAG_MAX;
            occ0      <= 1'b0;
            occ1      <= 1'b0;
            llr.ready <= 1'b0;
            load_done <= 1'b0;
            hd_bits   <= '0;
            lr_valid  <= 1'b0;
            lr_idx0   <= '0;
            lr_idx1   <= '0;
        end else if (set && (code != 2'd0)) begin
            // A new configuration restarts from any state; a coincident beat is dropped
            state     <= LOAD;
            code_reg  <= code;
            mode_reg  <= mode;
            cnt       <= '0;
            min0      <= MAG_MAX;
            min1      <= MAG_MAX;
            occ0      <= 1'b0;
            occ1      <= 1'b0;
            llr.ready <= 1'b1;
            load_done <= 1'b0;
            hd_bits   <= '0;
            lr_valid  <= 1'b0;
            lr_idx0   <= '0;
            lr_idx1   <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        for (int l = 0; l < int'(LANES); l++) begin
                            if (lane_ok[l] && (pos[l] < IDX_W'(MAX_N)))
                                hd_bits[pos[l]] <= sgn[l];
                        end
                        if (mode_reg) begin
                            min0    <= ins0_m;
                            min1    <= ins1_m;
                            occ0    <= ins0_v;
                            occ1    <= ins1_v;
                            lr_idx0 <= ins0_i;
                            lr_idx1 <= ins1_i;
                        end
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == last_cnt) begin
                            state     <= DONE;
                            llr.ready <= 1'b0;
                            load_done <= 1'b1;
                            lr_valid  <= mode_reg;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bch_llr_loader.sv
// Self-checking bench for bch_llr_loader: directed table vectors, hand-written
// restart/reset sequences and randomized loads against a sorting reference model.
module tb_bch_llr_loader;

    localparam int unsigned LANES = 8;
    localparam int unsigned LLR_W = 8;
    localparam int unsigned MAX_N = 1023;
    localparam int unsigned IDX_W = 10;

    logic             clk  = 1'b0;
    logic             rstn = 1'b0;
    logic             set  = 1'b0;
    logic [1:0]       code = 2'd0;
    logic             mode = 1'b0;
    logic             load_done;
    logic [MAX_N-1:0] hd_bits;
    logic             lr_valid;
    logic [IDX_W-1:0] lr_idx0;
    logic [IDX_W-1:0] lr_idx1;

    bch_llr_loader_if #(.LANES(LANES), .LLR_W(LLR_W)) llr();

    bch_llr_loader #(.LANES(LANES), .LLR_W(LLR_W), .MAX_N(MAX_N), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .set       (set),
        .code      (code),
        .mode      (mode),
        .llr       (llr),
        .load_done (load_done),
        .hd_bits   (hd_bits),
        .lr_valid  (lr_valid),
        .lr_idx0   (lr_idx0),
        .lr_idx1   (lr_idx1)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;

    // Symbol stream indexed by global stream index s (s=0 is the padding symbol)
    logic signed [7:0] strm [1024];
    logic [MAX_N-1:0]  m_hd;
    int                m_i0, m_i1;

    typedef struct {
        int code; bit mode; int base; int pad; int stall;
        int sp0; int sv0; int sp1; int sv1; int sp2; int sv2;
        int exp0; int exp1; int exp_hd;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_hd(input string name, input logic [MAX_N-1:0] exp);
        int first;
        checks++;
        if (hd_bits !== exp) begin
            errors++;
            first = -1;
            for (int i = 0; i < int'(MAX_N); i++)
                if (first < 0 && hd_bits[i] !== exp[i]) first = i;
            $display("FAIL %s hd_bits first differing bit %0d actual=%b required=%b",
                     name, first, hd_bits[first], exp[first]);
        end
    endtask

    function automatic int nlen(input int c);
        return (c == 1) ? 63 : (c == 2) ? 255 : 1023;
    endfunction

    function automatic int magof(input logic signed [7:0] v);
        int x;
        x = int'(v);
        if (x == -128) return 127;
        return (x < 0) ? -x : x;
    endfunction

    // Reference: hard bits from signs; least-reliable pair by scanning in arrival order
    task automatic model(input int n, input bit m);
        int best, sec;
        m_hd = '0;
        for (int s = 1; s <= n; s++)
            if (strm[s] < 0) m_hd[n - s] = 1'b1;
        best = -1;
        for (int s = 1; s <= n; s++)
            if (best < 0 || magof(strm[s]) < magof(strm[best])) best = s;
        sec = -1;
        for (int s = 1; s <= n; s++)
            if (s != best && (sec < 0 || magof(strm[s]) < magof(strm[sec]))) sec = s;
        m_i0 = m ? n - best : 0;
        m_i1 = m ? n - sec  : 0;
    endtask

    function automatic logic [LANES*LLR_W-1:0] beat_of(input int b);
        logic [LANES*LLR_W-1:0] d;
        d = '0;
        for (int l = 0; l < int'(LANES); l++)
            d[(int'(LANES) - 1 - l) * int'(LLR_W) +: LLR_W] = strm[b * int'(LANES) + l];
        return d;
    endfunction

    task automatic do_set(input int c, input bit m, input bit with_beat);
        set  = 1'b1;
        code = 2'(c);
        mode = m;
        if (with_beat) begin
            llr.in_valid = 1'b1;
            llr.idata    = {LANES{8'h81}};
        end
        @(posedge clk); #1;
        set          = 1'b0;
        llr.in_valid = 1'b0;
    endtask

    task automatic feed(input string name, input int nb, input int stall, input bit final_done);
        int b, cyc;
        bit acc;
        b = 0;
        cyc = 0;
        while (b < nb && cyc < 4000) begin
            if (int'($urandom_range(0, 99)) < stall) begin
                llr.in_valid = 1'b0;
                llr.idata    = {$urandom, $urandom};
            end else begin
                llr.in_valid = 1'b1;
                llr.idata    = beat_of(b);
            end
            acc = llr.in_valid && llr.ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                b++;
                chk({name, "/load_done"}, 64'(load_done), 64'((b == nb) && final_done));
            end
        end
        llr.in_valid = 1'b0;
        if (b < nb) begin
            checks++;
            errors++;
            $display("FAIL %s timeout beats=%0d required=%0d", name, b, nb);
        end
    endtask

    task automatic check_results(input string name, input int n, input bit m);
        logic [MAX_N-1:0] held;
        model(n, m);
        chk_hd({name, "/hd"}, m_hd);
        chk({name, "/lr_valid"}, 64'(lr_valid), 64'(m));
        chk({name, "/idx0"}, 64'(lr_idx0), 64'(m_i0));
        chk({name, "/idx1"}, 64'(lr_idx1), 64'(m_i1));
        chk({name, "/ready"}, 64'(llr.ready), 64'(0));
        // Results must hold while stray beats arrive in DONE
        held = m_hd;
        for (int i = 0; i < 3; i++) begin
            llr.in_valid = 1'b1;
            llr.idata    = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        llr.in_valid = 1'b0;
        chk_hd({name, "/hold_hd"}, held);
        chk({name, "/hold_done"}, 64'(load_done), 64'(1));
        chk({name, "/hold_idx0"}, 64'(lr_idx0), 64'(m_i0));
    endtask

    vec_t vec [4];

    initial begin
        int n, p, v, r;
        bit m;
        llr.in_valid = 1'b0;
        llr.idata    = '0;

        vec[0] = '{1, 1'b0,  5,    5, 0,   62, -3,  -1, 0,  -1, 0,  0,    0,    62};
        vec[1] = '{2, 1'b1, 40,   40, 0,  200, -2,  17, 1,  -1, 0,  17,   200,  200};
        vec[2] = '{3, 1'b1, 60, -128, 40, 1022, -128, -1, 0, -1, 0,  1021, 1020, 1022};
        vec[3] = '{1, 1'b1, 20,   20, 0,   50,  3,  40, 3,  10, 3,  50,   40,   -1};

        #12;
        chk("reset/ready", 64'(llr.ready), 64'(0));
        chk("reset/load_done", 64'(load_done), 64'(0));
        chk_hd("reset/hd", '0);
        chk("reset/lr_valid", 64'(lr_valid), 64'(0));
        chk("reset/idx0", 64'(lr_idx0), 64'(0));
        rstn = 1'b1;
        @(posedge clk); #1;

        foreach (vec[i]) begin
            n = nlen(vec[i].code);
            for (int s = 0; s <= n; s++) begin
                p = n - s;
                v = (s == 0) ? vec[i].pad : vec[i].base;
                if (s != 0 && p == vec[i].sp0) v = vec[i].sv0;
                if (s != 0 && p == vec[i].sp1) v = vec[i].sv1;
                if (s != 0 && p == vec[i].sp2) v = vec[i].sv2;
                strm[s] = 8'(v);
            end
            do_set(vec[i].code, vec[i].mode, 1'b0);
            chk($sformatf("vec%0d/ready_after_set", i), 64'(llr.ready), 64'(1));
            feed($sformatf("vec%0d", i), (n + 1) / int'(LANES), vec[i].stall, 1'b1);
            chk($sformatf("vec%0d/tbl_idx0", i), 64'(lr_idx0), 64'(vec[i].exp0));
            chk($sformatf("vec%0d/tbl_idx1", i), 64'(lr_idx1), 64'(vec[i].exp1));
            if (vec[i].exp_hd >= 0)
                chk($sformatf("vec%0d/tbl_hdbit", i), 64'(hd_bits[vec[i].exp_hd]), 64'(1));
            check_results($sformatf("vec%0d", i), n, vec[i].mode);
        end

        // Restart mid-load: code 3 interrupted after 5 beats by a code 2 set
        for (int s = 0; s <= 1023; s++) strm[s] = 8'(int'($urandom_range(0, 255)) - 128);
        do_set(3, 1'b1, 1'b0);
        feed("restart/pre", 5, 0, 1'b0);
        for (int s = 0; s <= 255; s++) strm[s] = 8'sd10;
        strm[7]  = -8'sd4;
        strm[90] = 8'sd2;
        do_set(2, 1'b1, 1'b1);
        chk_hd("restart/cleared", '0);
        chk("restart/load_done", 64'(load_done), 64'(0));
        chk("restart/ready", 64'(llr.ready), 64'(1));
        feed("restart/post", 32, 20, 1'b1);
        check_results("restart", 255, 1'b1);

        // Asynchronous reset between edges mid-load, then an invalid set
        for (int s = 0; s <= 255; s++) strm[s] = -8'sd9;
        do_set(2, 1'b1, 1'b0);
        feed("areset/pre", 10, 0, 1'b0);
        #3;
        rstn = 1'b0;
        #1;
        chk("areset/ready", 64'(llr.ready), 64'(0));
        chk("areset/load_done", 64'(load_done), 64'(0));
        chk_hd("areset/hd", '0);
        #2;
        rstn = 1'b1;
        @(posedge clk); #1;
        do_set(0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            llr.in_valid = 1'b1;
            llr.idata    = {LANES{8'h80}};
            @(posedge clk); #1;
        end
        llr.in_valid = 1'b0;
        chk("idle/ready", 64'(llr.ready), 64'(0));
        chk("idle/load_done", 64'(load_done), 64'(0));
        chk_hd("idle/hd", '0);

        // Randomized loads checked against the reference model
        for (int t = 0; t < 8; t++) begin
            code = 2'd0;
            n = nlen(int'($urandom_range(1, 3)));
            m = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 1) == 0) ? 4 : 127;
            for (int s = 0; s <= n; s++) begin
                if ($urandom_range(0, 15) == 0) strm[s] = -8'sd128;
                else strm[s] = 8'(int'($urandom_range(0, 2 * r)) - r);
            end
            do_set((n == 63) ? 1 : (n == 255) ? 2 : 3, m, 1'b0);
            feed($sformatf("rand%0d", t), (n + 1) / int'(LANES), 30, 1'b1);
            check_results($sformatf("rand%0d", t), n, m);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bch_llr_loader.md
Name: bch_llr_loader

Overview:
Input front-end for the BCH decoder that supports all three code configurations: (63,51), (255,239) and (1023,983). It accepts beats of packed LLRs through a valid/ready handshake and strips the leading padding symbol. It stores the hard-decision bit of every code position. In soft mode it also tracks the two least-reliable positions for the downstream Chase/syndrome stages. Results are held stable until the next configuration pulse.

Parameters:
LANES, 8, LLRs per input beat; must be a power of 2 and must divide 64.
LLR_W, 8, width of one signed two's-complement LLR.
MAX_N, 1023, longest supported code length; sets the hd_bits width.
IDX_W, 10, position index width; must satisfy 2^IDX_W > MAX_N.

Ports:
clk  in  1  clock; all logic on the rising edge.
rstn  in  1  asynchronous, active-low reset.
set  in  1  one-cycle pulse; latches code and mode, then starts a new codeword.
code  in  2  code select: 1 = n=63, 2 = n=255, 3 = n=1023, 0 = invalid.
mode  in  1  0 = hard-decision, 1 = soft-decision.
in_valid  in  1  idata carries a valid beat.
idata  in  LANES*LLR_W  packed LLRs; lane 0 is the MSB slice and is received first.
ready  out  1  the loader accepts a beat this cycle.
load_done  out  1  the codeword is fully loaded; results are valid.
hd_bits  out  MAX_N  hard bit per position; bit p is the coefficient of x^p.
lr_valid  out  1  lr_idx0 and lr_idx1 are meaningful (soft mode only).
lr_idx0  out  IDX_W  position with the smallest |LLR|.
lr_idx1  out  IDX_W  position with the second-smallest |LLR|.

Behaviour:
- Reset (asynchronous, rstn=0) sets:
  - state = IDLE.
  - All outputs = 0, hd_bits = 0.
  - Beat counter = 0, code_reg = 0, mode_reg = 0.
  - Trackers min0 = min1 = all-ones magnitude.
- Code length n = 63, 255 or 1023. Number of beats B = (n+1)/LANES, which gives 8, 32 or 128 for LANES=8.
- Position mapping:
  - Lane 0 of beat 0 is padding. It is ignored for hd_bits and for the trackers.
  - The symbol at global stream index s (s = beat*LANES + lane, s >= 1) maps to position p = n - s. The first real symbol is therefore p = n-1.
- Hard bit = sign bit (MSB) of the LLR: negative gives 1.
- Magnitude = |LLR|, with the most-negative value saturated to 2^(LLR_W-1)-1.
- State machine (3 states):
  - IDLE: ready=0. A set with code != 0 goes to LOAD. A set with code == 0 is ignored.
  - LOAD: ready=1. A beat is accepted when in_valid && ready. On an accepted beat:
    - Write the hard bits for all non-padding lanes.
    - In soft mode, update the trackers.
    - Increment the counter.
    - On acceptance of beat B-1, go to DONE. load_done rises on the next cycle.
  - DONE: ready=0. load_done=1. hd_bits and lr_* are held. A set starts a new load.
- Any set with code != 0, in any state including mid-LOAD:
  - Latch code and mode; clear hd_bits, the counter and the trackers; drop load_done and lr_valid.
  - Enter LOAD next cycle. ready=1 from that next cycle.
  - A beat presented in the same cycle as set is discarded.
- hd_bits positions >= n stay 0.
- Tracker update (soft mode only), once per accepted beat:
  - Find the two smallest magnitudes among the valid lanes.
  - Merge them with the running min0 and min1, keeping min0 <= min1 by magnitude.
  - Tie-break: the earlier-received symbol (higher p) wins. The update compares with < against stored entries, so a later equal magnitude never displaces a stored one.
  - idx0 != idx1 always.
- lr_valid = mode_reg && load_done. In hard mode, lr_idx0 and lr_idx1 stay 0.
- in_valid outside LOAD is ignored. idata is don't-care when in_valid = 0; stalls of any length are allowed.
- Per-beat merge: no multicycle paths. Single-cycle, registered outputs; latency from last beat accepted to load_done is 1 cycle.

Test Plan:
1. Code 1, hard mode, 8 beats, all LLRs = +5 except the symbol at s=1 = -3 → hd_bits[62]=1, every other bit 0; load_done rises 1 cycle after the 8th beat; lr_valid = 0.
2. Code 2, soft mode, 32 beats, all LLRs = +40 except p=200 = -2 and p=17 = +1 → lr_idx0 = 17, lr_idx1 = 200, hd_bits[200] = 1, lr_valid = 1.
3. Code 3, soft mode, 128 beats with in_valid toggled randomly; padding lane = -128, all others = +60 except p=1022 = -128 → padding has no effect; hd_bits[1022] = 1; lr_idx0 is not 1022, since |-128| saturates to 127 and is the largest magnitude.
4. Tie case, soft, code 1: magnitude 3 at p=50, p=40 and p=10, all others 20 → lr_idx0 = 50, lr_idx1 = 40.
5. set with code=2 pulsed after 5 beats of a code-3 load; the beat presented in the set cycle is discarded → hd_bits cleared; exactly 32 further beats are needed before load_done.
6. rstn dropped mid-LOAD (asynchronously, between edges) → ready, load_done and hd_bits go to 0 immediately; a set with code=0 afterwards leaves the block in IDLE with ready = 0.
